// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared word type, memory-controller state encoding and
//               LL/SC result constants for the data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memctrl_state_t;

  // Value written back by a store-conditional
  localparam word_t SC_SUCCESS = 32'd1;
  localparam word_t SC_FAIL    = 32'd0;

endpackage

`default_nettype wire

// File: rtl/link_reg.sv
// ============================================================================
// Module      : link_reg
// Description : LL/SC reservation register. Holds the linked address and a
//               valid bit; set by LL completion, cleared by SC completion,
//               halt, a local store to the linked address or a remote
//               snoop invalidation of the linked address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_reg
  import cpu_types_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        set_i,        // LL completing this cycle
  input  logic        clr_i,        // SC completion or halt
  input  logic        store_i,      // local plain store completing this cycle
  input  logic [31:0] addr_i,       // address of the local access
  input  logic        snoop_inv_i,
  input  logic [31:0] snoop_addr_i,
  output logic        valid_o,
  output logic [31:0] addr_o
);

  logic  valid_q, valid_d;
  word_t addr_q,  addr_d;

  // Next link state; a completing LL wins over a same-cycle snoop
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end else if (store_i && (addr_i == addr_q)) begin
      valid_d = 1'b0;
    end else if (snoop_inv_i && (snoop_addr_i == addr_q)) begin
      valid_d = 1'b0;
    end
  end

  // Link register storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data memory access controller. Turns the EX/MEM
//               latched load/store/LL/SC request into held memory strobes,
//               stalls the pipeline until completion, captures the
//               writeback word and maintains the LL/SC reservation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dread,
  input  logic        dwrite,
  input  logic        datomic,
  input  logic        halt,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        snoopInv,
  input  logic [31:0] snoopAddr,
  output logic        memStall,
  output logic [31:0] loadData
);

  memctrl_state_t state_q, state_d;
  word_t          load_data_q, load_data_d;

  logic  stall_c;
  logic  link_set, link_clr, link_store;
  logic  link_valid;
  word_t link_addr;
  logic  is_sc;
  logic  sc_ok;

  // A store with the atomic flag is an SC; a set read flag takes precedence
  assign is_sc = dwrite && !dread && datomic;
  assign sc_ok = link_valid && (link_addr == addr);

  // Next-state, strobe, stall and link-control decode
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    link_set    = 1'b0;
    link_clr    = 1'b0;
    link_store  = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          link_clr = 1'b1;
        end else if (dread || dwrite) begin
          stall_c = 1'b1;
          if (is_sc && !sc_ok) begin
            // Lost reservation: resolve without touching memory
            state_d     = DONE;
            load_data_d = SC_FAIL;
            link_clr    = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        dmemREN = dread;
        dmemWEN = dwrite;
        if (dhit) begin
          state_d = DONE;
          if (dread) begin
            load_data_d = dmemload;
            link_set    = datomic;
          end else if (dwrite) begin
            if (datomic) begin
              load_data_d = SC_SUCCESS;
              link_clr    = 1'b1;
            end else begin
              link_store = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and writeback-word registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  link_reg u_link (
    .clk_i        (CLK),
    .rst_ni       (nRST),
    .set_i        (link_set),
    .clr_i        (link_clr),
    .store_i      (link_store),
    .addr_i       (addr),
    .snoop_inv_i  (snoopInv),
    .snoop_addr_i (snoopAddr),
    .valid_o      (link_valid),
    .addr_o       (link_addr)
  );

  // Stall is masked during reset so a pending request cannot freeze the pipe
  assign memStall  = stall_c && nRST;
  assign loadData  = load_data_q;
  assign dmemaddr  = addr;
  assign dmemstore = storeData;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with directed
//               scenarios and randomized transactions against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dread, dwrite, datomic, halt;
  logic [31:0] addr, storeData;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        snoopInv;
  logic [31:0] snoopAddr;
  logic        memStall;
  logic [31:0] loadData;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: reservation and last writeback word
  logic        m_valid;
  logic [31:0] m_laddr;
  logic [31:0] m_ld;

  mem_access_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dread     (dread),
    .dwrite    (dwrite),
    .datomic   (datomic),
    .halt      (halt),
    .addr      (addr),
    .storeData (storeData),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .snoopInv  (snoopInv),
    .snoopAddr (snoopAddr),
    .memStall  (memStall),
    .loadData  (loadData)
  );

  always #5 CLK = ~CLK;

  // Transaction-level model: strobe length, stall length and writeback word
  task automatic model_txn(input logic rd, input logic wr, input logic at, input logic hlt,
                           input logic [31:0] a, input logic [31:0] rdata, input int delay,
                           input logic snp, input logic [31:0] saddr,
                           output int e_stall, output int e_ren, output int e_wen,
                           output logic [31:0] e_ld);
    e_stall = 0; e_ren = 0; e_wen = 0;
    if (hlt) begin
      m_valid = 1'b0;
    end else if (rd) begin
      e_ren = delay + 1; e_stall = delay + 2; m_ld = rdata;
      if (at) begin
        m_valid = 1'b1; m_laddr = a;
      end else if (snp && saddr == m_laddr) begin
        m_valid = 1'b0;
      end
    end else if (wr) begin
      if (at) begin
        if (m_valid && m_laddr == a) begin
          e_wen = delay + 1; e_stall = delay + 2; m_ld = 32'd1;
        end else begin
          e_stall = 1; m_ld = 32'd0;
        end
        m_valid = 1'b0;
      end else begin
        e_wen = delay + 1; e_stall = delay + 2;
        if (a == m_laddr) m_valid = 1'b0;
        if (snp && saddr == m_laddr) m_valid = 1'b0;
      end
    end
    e_ld = m_ld;
  endtask

  // Present one EX/MEM request and act as memory until the pipe advances
  task automatic run_txn(input logic rd, input logic wr, input logic at, input logic hlt,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                         input int delay, input logic snp, input logic [31:0] saddr,
                         output int n_stall, output int n_ren, output int n_wen,
                         output logic path_ok, output logic [31:0] ld);
    int   k;
    logic fin;
    logic strobe;
    n_stall = 0; n_ren = 0; n_wen = 0; path_ok = 1'b1; ld = 32'hx; k = 0; fin = 1'b0;
    dread = rd; dwrite = wr; datomic = at; halt = hlt; addr = a; storeData = sd;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (dmemaddr !== a || dmemstore !== sd) path_ok = 1'b0;
      strobe = (dmemREN === 1'b1) || (dmemWEN === 1'b1);
      if (dmemREN === 1'b1) n_ren++;
      if (dmemWEN === 1'b1) n_wen++;
      if (strobe) begin
        dhit = (k == delay);
        k++;
      end else begin
        dhit = 1'($urandom_range(0, 1));
      end
      dmemload  = (strobe && dhit) ? rdata : $urandom;
      snoopInv  = snp && strobe && dhit;
      snoopAddr = saddr;
      if (memStall === 1'b0) begin
        ld  = loadData;
        fin = 1'b1;
      end else begin
        n_stall++;
      end
      @(posedge CLK); #1;
      if (fin) break;
    end
    if (!fin) begin
      n_checks++; n_errors++;
      $display("FAIL txn_timeout: memStall still %b after 64 cycles, want 0", memStall);
    end
    dread = 1'b0; dwrite = 1'b0; datomic = 1'b0; halt = 1'b0;
    dhit = 1'b0; snoopInv = 1'b0;
  endtask

  // Bubble cycle with optional remote invalidation
  task automatic idle_cycle(input logic snp, input logic [31:0] saddr);
    dread = 1'b0; dwrite = 1'b0; halt = 1'b0;
    snoopInv = snp; snoopAddr = saddr; dhit = 1'($urandom_range(0, 1));
    #1;
    n_checks++;
    if (memStall !== 1'b0) begin
      n_errors++; $display("FAIL idle_stall: got %b want 0", memStall);
    end
    if (snp && m_valid && saddr == m_laddr) m_valid = 1'b0;
    @(posedge CLK); #1;
    snoopInv = 1'b0; dhit = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; dread = 1'b1; dwrite = 1'b0; datomic = 1'b0; halt = 1'b0;
    addr = 32'h100; storeData = 32'h0; dhit = 1'b0; dmemload = 32'h0;
    snoopInv = 1'b0; snoopAddr = 32'h0;
    m_valid = 1'b0; m_laddr = 32'h0; m_ld = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (memStall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", memStall); end
    n_checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got %b%b want 00", dmemREN, dmemWEN); end
    n_checks++; if (loadData !== 32'h0) begin n_errors++; $display("FAIL reset_loaddata: got %h want 0", loadData); end
    n_checks++; if (dmemaddr !== 32'h100) begin n_errors++; $display("FAIL reset_addr: got %h want 100", dmemaddr); end
    dread = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_load();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (r !== 1) begin n_errors++; $display("FAIL load_ren: got %0d want 1", r); end
    n_checks++; if (s !== 2) begin n_errors++; $display("FAIL load_stall: got %0d want 2", s); end
    n_checks++; if (l !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_data: got %h want deadbeef", l); end
    n_checks++; if (!p) begin n_errors++; $display("FAIL load_path: got mismatch want passthrough"); end
  endtask

  task automatic test_store_delay();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(0, 1, 0, 0, 32'h200, 32'h0, 3, 0, 0, es, er, ew, el);
    run_txn(0, 1, 0, 0, 32'h200, 32'h1234, 32'h0, 3, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 4 || r !== 0) begin n_errors++; $display("FAIL store_wen: got wen=%0d ren=%0d want 4/0", w, r); end
    n_checks++; if (s !== 5) begin n_errors++; $display("FAIL store_stall: got %0d want 5", s); end
    n_checks++; if (l !== el) begin n_errors++; $display("FAIL store_keeps_data: got %h want %h", l, el); end
    n_checks++; if (!p) begin n_errors++; $display("FAIL store_path: got mismatch want passthrough"); end
  endtask

  // LL then two SCs: first succeeds, second finds reservation consumed
  task automatic test_llsc();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 1, 0, 32'h300, 32'hCAFE0001, 1, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'hCAFE0001, 1, 0, 0, s, r, w, p, l);
    n_checks++; if (l !== 32'hCAFE0001 || s !== 3) begin n_errors++; $display("FAIL ll_data: got %h/%0d want cafe0001/3", l, s); end
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h55, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 1 || l !== 32'd1) begin n_errors++; $display("FAIL sc_ok: got wen=%0d ld=%h want 1/1", w, l); end
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h66, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 0 || l !== 32'd0 || s !== 1) begin n_errors++; $display("FAIL sc_again: got wen=%0d ld=%h stall=%0d want 0/0/1", w, l, s); end
  endtask

  // Snoops: other address keeps link, matching address kills it
  task automatic test_snoop_kill();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 1, 0, 32'h300, 32'h11, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h11, 0, 0, 0, s, r, w, p, l);
    idle_cycle(1, 32'h304);
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h1, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 1 || l !== 32'd1) begin n_errors++; $display("FAIL snoop_other: got wen=%0d ld=%h want 1/1", w, l); end
    model_txn(1, 0, 1, 0, 32'h300, 32'h22, 2, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h22, 2, 0, 0, s, r, w, p, l);
    idle_cycle(1, 32'h300);
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h2, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 0 || l !== 32'd0) begin n_errors++; $display("FAIL snoop_kill: got wen=%0d ld=%h want 0/0", w, l); end
  endtask

  // Snoop in the LL completion cycle loses to the LL
  task automatic test_ll_snoop_same();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 1, 0, 32'h300, 32'h33, 0, 1, 32'h300, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h33, 0, 1, 32'h300, s, r, w, p, l);
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 1, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h3, 32'h0, 1, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 2 || l !== 32'd1) begin n_errors++; $display("FAIL ll_snoop_same: got wen=%0d ld=%h want 2/1", w, l); end
  endtask

  // Local store to the link and halt each drop the reservation
  task automatic test_store_halt_kill();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 1, 0, 32'h300, 32'h44, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h44, 0, 0, 0, s, r, w, p, l);
    model_txn(0, 1, 0, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 0, 0, 32'h300, 32'h9, 32'h0, 0, 0, 0, s, r, w, p, l);
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h4, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 0 || l !== 32'd0) begin n_errors++; $display("FAIL store_kill: got wen=%0d ld=%h want 0/0", w, l); end
    model_txn(1, 0, 1, 0, 32'h300, 32'h55, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h55, 0, 0, 0, s, r, w, p, l);
    model_txn(1, 0, 0, 1, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 0, 1, 32'h300, 32'h0, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (s !== 0 || r !== 0 || l !== 32'h55) begin n_errors++; $display("FAIL halt_noreq: got stall=%0d ren=%0d ld=%h want 0/0/55", s, r, l); end
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h5, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 0 || l !== 32'd0) begin n_errors++; $display("FAIL halt_kill: got wen=%0d ld=%h want 0/0", w, l); end
  endtask

  // Reset arriving while a load is waiting on memory
  task automatic test_reset_mid_access();
    int s, r, w, es, er, ew; logic p; logic [31:0] l, el;
    model_txn(1, 0, 1, 0, 32'h300, 32'h77, 0, 0, 0, es, er, ew, el);
    run_txn(1, 0, 1, 0, 32'h300, 32'h0, 32'h77, 0, 0, 0, s, r, w, p, l);
    dread = 1'b1; addr = 32'h400; dhit = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    n_checks++; if (dmemREN !== 1'b1 || memStall !== 1'b1) begin n_errors++; $display("FAIL midrst_pre: got ren=%b stall=%b want 1/1", dmemREN, memStall); end
    nRST = 1'b0;
    #1;
    n_checks++; if (dmemREN !== 1'b0 || memStall !== 1'b0) begin n_errors++; $display("FAIL midrst_drop: got ren=%b stall=%b want 0/0", dmemREN, memStall); end
    n_checks++; if (loadData !== 32'h0) begin n_errors++; $display("FAIL midrst_data: got %h want 0", loadData); end
    m_valid = 1'b0; m_laddr = 32'h0; m_ld = 32'h0;
    dread = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    model_txn(0, 1, 1, 0, 32'h300, 32'h0, 0, 0, 0, es, er, ew, el);
    run_txn(0, 1, 1, 0, 32'h300, 32'h6, 32'h0, 0, 0, 0, s, r, w, p, l);
    n_checks++; if (w !== 0 || l !== 32'd0) begin n_errors++; $display("FAIL midrst_link: got wen=%0d ld=%h want 0/0", w, l); end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h300;
      1:       return 32'h304;
      2:       return 32'h1000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int s, r, w, es, er, ew, kind, dly; logic p, snp, rd, wr, at, hl;
    logic [31:0] l, el, a, sa, rdat, sd;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 6);
      a = pick_addr(); sa = pick_addr(); rdat = $urandom; sd = $urandom;
      dly = $urandom_range(0, 3); snp = ($urandom_range(0, 3) == 0);
      if (kind == 6) begin
        idle_cycle(1'b1, sa);
      end else begin
        rd = (kind == 0) || (kind == 1); wr = (kind == 2) || (kind == 3) || (kind == 4);
        at = (kind == 1) || (kind == 3) || (kind == 4); hl = (kind == 5);
        if (hl) begin rd = 1'($urandom_range(0, 1)); wr = !rd; end
        model_txn(rd, wr, at, hl, a, rdat, dly, snp, sa, es, er, ew, el);
        run_txn(rd, wr, at, hl, a, sd, rdat, dly, snp, sa, s, r, w, p, l);
        n_checks++; if (s !== es) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, s, es); end
        n_checks++; if (r !== er) begin n_errors++; $display("FAIL rnd_ren[%0d]: got %0d want %0d", i, r, er); end
        n_checks++; if (w !== ew) begin n_errors++; $display("FAIL rnd_wen[%0d]: got %0d want %0d", i, w, ew); end
        n_checks++; if (l !== el) begin n_errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, l, el); end
        n_checks++; if (!p) begin n_errors++; $display("FAIL rnd_path[%0d]: got mismatch want passthrough", i); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_delay();
    test_llsc();
    test_snoop_kill();
    test_ll_snoop_same();
    test_store_halt_kill();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port dread, input, 1, EX/MEM latched load request.
REQ-004 SHALL have port dwrite, input, 1, EX/MEM latched store request.
REQ-005 SHALL have port datomic, input, 1, EX/MEM latched atomic flag (LL when dread, SC when dwrite).
REQ-006 SHALL have port halt, input, 1, EX/MEM latched halt.
REQ-007 SHALL have port addr, input, 32, EX/MEM latched ALU result used as byte address.
REQ-008 SHALL have port storeData, input, 32, EX/MEM latched store data.
REQ-009 SHALL have ports dmemREN and dmemWEN, output, 1 each, memory read/write strobes.
REQ-010 SHALL have ports dmemaddr and dmemstore, output, 32 each, memory address and write data.
REQ-011 SHALL have ports dhit, input, 1, memory completion, and dmemload, input, 32, read data.
REQ-012 SHALL have ports snoopInv, input, 1, and snoopAddr, input, 32, remote-write invalidation.
REQ-013 SHALL have port memStall, output, 1, high freezes EX/MEM and upstream latches (drives their EN low).
REQ-014 SHALL have port loadData, output, 32, captured load / SC result word for writeback.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DONE.
REQ-016 IDLE: dread or dwrite with halt=0 SHALL go to ACCESS next cycle, except a failing SC, which SHALL go to DONE.
REQ-017 A failing SC (linkValid=0 or linkAddr!=addr) SHALL issue no memory strobe and SHALL set loadData=0.
REQ-018 ACCESS SHALL hold dmemREN=dread, dmemWEN=dwrite, dmemaddr=addr, dmemstore=storeData until dhit.
REQ-019 Strobes SHALL be 0 in IDLE and DONE; dmemaddr and dmemstore SHALL follow addr and storeData in all states.
REQ-020 On dhit in ACCESS: load or LL SHALL capture dmemload into loadData; successful SC SHALL set loadData=1; next state DONE.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-022 memStall SHALL be (IDLE and (dread or dwrite) and not halt) or ACCESS; it SHALL be 0 in DONE.
REQ-023 LL completion SHALL set linkValid=1 and linkAddr=addr.
REQ-024 SC completion, success or fail, SHALL clear linkValid.
REQ-025 snoopInv with snoopAddr==linkAddr SHALL clear linkValid, except in a cycle where LL completion sets the link; LL completion SHALL take priority.
REQ-026 A local plain store completing to linkAddr SHALL clear linkValid.
REQ-027 halt=1 SHALL clear linkValid and SHALL issue no request.
REQ-028 Minimum access latency SHALL be 3 cycles, request seen to latch advance, with dhit in the first ACCESS cycle.
REQ-029 dhit outside ACCESS SHALL be ignored.
REQ-030 Addresses SHALL pass unmodified, with no alignment checking.

Reset
REQ-031 nRST low SHALL force state=IDLE, linkValid=0, linkAddr=0, loadData=0, dmemREN=0, dmemWEN=0 and memStall=0, including mid-ACCESS; the transaction is abandoned.

Structure
REQ-032 word_t and the state enum memctrl_state_t SHALL be in cpu_types_pkg.
REQ-033 The LL/SC link register, with its set, clear and snoop-compare logic, SHALL be sub-module link_reg.

Verification
REQ-034 Load: addr=0x100, dread=1, dhit one cycle later with dmemload=0xDEADBEEF -> dmemREN high 1 cycle, loadData=0xDEADBEEF, memStall falls in DONE.
REQ-035 Store with 4-cycle dhit delay: addr=0x200, storeData=0x1234 -> dmemWEN held 4 cycles, memStall high 5 cycles.
REQ-036 LL 0x300, then SC 0x300 -> SC issues write, loadData=1, linkValid=0.
REQ-037 LL 0x300, snoopInv 0x300, then SC 0x300 -> no dmemWEN, loadData=0.
REQ-038 nRST asserted mid-ACCESS -> strobes drop immediately, state IDLE, linkValid=0.
REQ-039 snoopInv 0x300 in the same cycle as LL 0x300 dhit -> linkValid=1, and the following SC succeeds.
